// File: rtl/vga_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_decoder
// Description : VGA pin-side receiver. Recovers pixel coordinates from the
//               hsync/vsync stream, checks frame timing, locks after a run of
//               clean frames, and decodes the displayed board by sampling one
//               pixel per 8x8 cell. Produces a cell stream plus per-frame
//               live-cell count.
//               Optional macro VGA_DEC_CRC_EN adds a CRC-16-CCITT of each
//               frame's cell stream on frame_crc; without it frame_crc is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_decoder #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_ACTIVE = 0,
    parameter int LOCK_FRAMES = 2,
    parameter int BOARD_COLS  = 64,
    parameter int BOARD_ROWS  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [1:0]  r,
    input  logic [1:0]  g,
    input  logic [1:0]  b,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        locked,
    output logic        timing_err,
    output logic [7:0]  err_count,
    output logic        cell_valid,
    output logic [10:0] cell_index,
    output logic        cell_alive,
    output logic        frame_done,
    output logic [11:0] alive_count,
    output logic [15:0] frame_crc
);

    // Board is centred in the visible area; 640x480 gives the 64..575 / 112..367 window.
    localparam logic [9:0] C_H_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] C_V_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] C_HS_X     = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] C_VS_Y     = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] C_HS_WIDTH = 10'(H_SYNC);
    localparam logic [9:0] C_VS_LINES = 10'(V_SYNC);
    localparam logic [9:0] C_WIN_X0   = 10'((H_DISPLAY - 8 * BOARD_COLS) / 2);
    localparam logic [9:0] C_WIN_Y0   = 10'((V_DISPLAY - 8 * BOARD_ROWS) / 2);
    localparam logic [9:0] C_WIN_X1   = 10'((H_DISPLAY - 8 * BOARD_COLS) / 2 + 8 * BOARD_COLS);
    localparam logic [9:0] C_WIN_Y1   = 10'((V_DISPLAY - 8 * BOARD_ROWS) / 2 + 8 * BOARD_ROWS);
    localparam logic [7:0] C_LOCK     = 8'(LOCK_FRAMES);
    localparam logic       C_SYNC_LVL = (SYNC_ACTIVE != 0);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_good;
    logic        r_hs_q;
    logic        r_vs_q;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [9:0]  r_hs_cnt;
    logic [9:0]  r_vs_lines;
    logic [11:0] r_acc;

    logic        w_hs_act, w_vs_act;
    logic        w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
    logic        w_wrap;
    logic [9:0]  w_x_pred, w_y_pred, w_x_new, w_y_new;
    logic [9:0]  w_vs_lines_done;
    logic        w_viol, w_err;
    logic [9:0]  w_cx, w_cy;
    logic        w_in_win, w_sample, w_alive, w_frame_end;
    logic        w_unused;

    // Sync edges are judged between the current pin sample and the previous one.
    assign w_hs_act  = (hsync == C_SYNC_LVL);
    assign w_vs_act  = (vsync == C_SYNC_LVL);
    assign w_hs_rise = w_hs_act & ~r_hs_q;
    assign w_hs_fall = ~w_hs_act & r_hs_q;
    assign w_vs_rise = w_vs_act & ~r_vs_q;
    assign w_vs_fall = ~w_vs_act & r_vs_q;

    // Free-running prediction; sync edges then snap the coordinates back into place.
    assign w_wrap   = (r_x == C_H_LAST);
    assign w_x_pred = w_wrap ? 10'd0 : r_x + 10'd1;
    assign w_y_pred = w_wrap ? ((r_y == C_V_LAST) ? 10'd0 : r_y + 10'd1) : r_y;
    assign w_x_new  = w_hs_rise ? C_HS_X : w_x_pred;
    assign w_y_new  = w_vs_rise ? C_VS_Y : w_y_pred;

    // The deasserting sample is the first of the line after the pulse, so count its wrap too.
    assign w_vs_lines_done = r_vs_lines + {9'd0, w_wrap};

    assign w_viol = (w_hs_rise && (w_x_pred != C_HS_X))
                  || (w_hs_fall && (r_hs_cnt != C_HS_WIDTH))
                  || (w_vs_rise && ((w_y_pred != C_VS_Y) || (w_x_pred != 10'd0)))
                  || (w_vs_fall && (w_vs_lines_done != C_VS_LINES));
    assign w_err  = w_viol && (r_state != ST_SEARCH);

    // Cell coordinates are relative to the window so index 0 is the top-left cell.
    assign w_cx        = w_x_new - C_WIN_X0;
    assign w_cy        = w_y_new - C_WIN_Y0;
    assign w_in_win    = (w_x_new >= C_WIN_X0) && (w_x_new < C_WIN_X1)
                       && (w_y_new >= C_WIN_Y0) && (w_y_new < C_WIN_Y1);
    assign w_sample    = (r_state == ST_LOCKED) && !w_err && w_in_win
                       && (w_cx[2:0] == 3'd3) && (w_cy[2:0] == 3'd3);
    assign w_alive     = (r == 2'b11) && (g == 2'b11);
    assign w_frame_end = (r_state == ST_LOCKED) && w_vs_rise && !w_err;
    assign w_unused    = ^{b, w_cx[9], w_cy[9:8]};

    assign pix_x = r_x;
    assign pix_y = r_y;

    // Coordinate recovery and sync pulse-width measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_q     <= 1'b0;
            r_vs_q     <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_hs_cnt   <= '0;
            r_vs_lines <= '0;
        end else begin
            r_hs_q <= w_hs_act;
            r_vs_q <= w_vs_act;
            r_x    <= w_x_new;
            r_y    <= w_y_new;
            if (w_hs_rise)
                r_hs_cnt <= 10'd1;
            else if (w_hs_act && (r_hs_cnt != 10'h3FF))
                r_hs_cnt <= r_hs_cnt + 10'd1;
            if (w_vs_rise)
                r_vs_lines <= '0;
            else if (w_vs_act && w_wrap && (r_vs_lines != 10'h3FF))
                r_vs_lines <= r_vs_lines + 10'd1;
        end
    end

    // Lock state machine; locked follows the state one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_SEARCH;
            r_good     <= '0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
            err_count  <= '0;
        end else begin
            locked     <= (r_state == ST_LOCKED);
            timing_err <= w_err;
            if (w_err) begin
                r_state <= ST_SEARCH;
                if (err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end else begin
                case (r_state)
                    ST_SEARCH: begin
                        if (w_vs_rise) begin
                            r_state <= ST_TRACK;
                            r_good  <= '0;
                        end
                    end
                    ST_TRACK: begin
                        if (w_vs_rise) begin
                            r_good <= r_good + 8'd1;
                            if ((r_good + 8'd1) >= C_LOCK)
                                r_state <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: r_state <= ST_LOCKED;
                    default:   r_state <= ST_SEARCH;
                endcase
            end
        end
    end

    // Cell stream and per-frame live-cell statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_valid  <= 1'b0;
            cell_index  <= '0;
            cell_alive  <= 1'b0;
            frame_done  <= 1'b0;
            alive_count <= '0;
            r_acc       <= '0;
        end else begin
            cell_valid <= w_sample;
            frame_done <= w_frame_end;
            if (w_sample) begin
                cell_index <= {w_cy[7:3], w_cx[8:3]};
                cell_alive <= w_alive;
            end
            if (w_frame_end)
                alive_count <= r_acc;
            if (w_vs_rise || w_err)
                r_acc <= '0;
            else if (w_sample && w_alive)
                r_acc <= r_acc + 12'd1;
        end
    end

`ifdef VGA_DEC_CRC_EN
    logic [15:0] r_crc;
    logic [15:0] w_crc_next;

    assign w_crc_next = {r_crc[14:0], 1'b0} ^ ((r_crc[15] ^ w_alive) ? 16'h1021 : 16'h0000);

    // CRC-16-CCITT over the cell stream, MSB-first, one bit per sampled cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc     <= 16'hFFFF;
            frame_crc <= '0;
        end else begin
            if (w_frame_end)
                frame_crc <= r_crc;
            if (w_vs_rise || w_err)
                r_crc <= 16'hFFFF;
            else if (w_sample)
                r_crc <= w_crc_next;
        end
    end
`else
    assign frame_crc = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_decoder
// Description : Scoreboard bench for vga_frame_decoder on a scaled-down
//               timing (84x43 total, 8x4 board) so many frames fit in a short
//               run. The generator knows the true pixel position of every
//               sample; the model predicts lock, cell stream and per-frame
//               results from the timing rules directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_decoder;

    localparam int H_DISPLAY = 68, H_FRONT = 4, H_SYNC = 6, H_BACK = 6;
    localparam int V_DISPLAY = 36, V_FRONT = 2, V_SYNC = 2, V_BACK = 3;
    localparam int BOARD_COLS = 8, BOARD_ROWS = 4;
    localparam int SYNC_ACTIVE = 0, LOCK_FRAMES = 2;
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_X = H_DISPLAY + H_FRONT;
    localparam int VS_Y = V_DISPLAY + V_FRONT;
    localparam int WX0 = (H_DISPLAY - 8 * BOARD_COLS) / 2;
    localparam int WY0 = (V_DISPLAY - 8 * BOARD_ROWS) / 2;
    localparam bit SYNC_LVL = (SYNC_ACTIVE != 0);
    localparam int LOCK_EDGES = LOCK_FRAMES + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync, vsync;
    logic [1:0]  r, g, b;
    logic [9:0]  pix_x, pix_y;
    logic        locked, timing_err, cell_valid, cell_alive, frame_done;
    logic [7:0]  err_count;
    logic [10:0] cell_index;
    logic [11:0] alive_count;
    logic [15:0] frame_crc;

    vga_frame_decoder #(
        .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_DISPLAY(V_DISPLAY), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .SYNC_ACTIVE(SYNC_ACTIVE), .LOCK_FRAMES(LOCK_FRAMES),
        .BOARD_COLS(BOARD_COLS), .BOARD_ROWS(BOARD_ROWS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b), .pix_x(pix_x), .pix_y(pix_y),
        .locked(locked), .timing_err(timing_err), .err_count(err_count),
        .cell_valid(cell_valid), .cell_index(cell_index), .cell_alive(cell_alive),
        .frame_done(frame_done), .alive_count(alive_count), .frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit locked; bit cv; bit te; bit fd; bit chk_xy; int x; int y;
    } cyc_t;
    typedef struct { int idx; bit alive; } cell_t;
    typedef struct { int cnt; logic [15:0] crc; } fd_t;

    cyc_t  cyc_q[$];
    cell_t cell_q[$];
    fd_t   fd_q[$];
    int    err_q[$];
    bit    bits_q[$];

    int checks = 0;
    int errors = 0;

    // Model state: clean vsync edges seen since the last reset/violation.
    int vs_seen, errs, acc;
    bit pending_short, prev_hs, prev_vs;
    bit board [0:BOARD_ROWS-1][0:BOARD_COLS-1];

    function automatic logic [15:0] crc_of_bits();
        logic [15:0] c;
        bit fb;
        c = 16'hFFFF;
        foreach (bits_q[i]) begin
            fb = c[15] ^ bits_q[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic model_reset();
        vs_seen = 0; errs = 0; acc = 0;
        pending_short = 0; prev_hs = 0; prev_vs = 0;
        bits_q.delete(); cyc_q.delete(); cell_q.delete(); fd_q.delete(); err_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({pix_x, pix_y, locked, timing_err, err_count, cell_valid, cell_index,
             cell_alive, frame_done, alive_count, frame_crc} !== '0) begin
            errors++;
            $display("FAIL %s: outputs not zero in reset (locked=%0b err_count=%0d alive_count=%0d frame_crc=%h pix=%0d,%0d) required all 0",
                     name, locked, err_count, alive_count, frame_crc, pix_x, pix_y);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midframe_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic drive_pixel(input int x, input int y, input int mode);
        bit hs_a, vs_a, hs_rise, vs_rise, in_win, alive, err;
        int cx, cy;
        cyc_t c;
        logic [15:0] ecrc;
        @(negedge clk);
        hs_a = (x >= HS_X) && (x < HS_X + H_SYNC);
        vs_a = (y >= VS_Y) && (y < VS_Y + V_SYNC);
        hsync = hs_a ? SYNC_LVL : ~SYNC_LVL;
        vsync = vs_a ? SYNC_LVL : ~SYNC_LVL;
        cx = x - WX0;
        cy = y - WY0;
        in_win = (cx >= 0) && (cx < 8 * BOARD_COLS) && (cy >= 0) && (cy < 8 * BOARD_ROWS);
        alive = 1'b0;
        if (in_win) begin
            case (mode)
                0:       alive = 1'b0;
                1:       alive = ((cx / 8) % 2 == 1) ^ ((cy / 8) % 2 == 1);
                2:       alive = board[cy / 8][cx / 8];
                default: alive = 1'b1;
            endcase
        end
        if (in_win && alive)   {r, g} = 4'hF;
        else if (in_win && mode == 0) {r, g} = 4'b0101;
        else if (in_win)       {r, g} = 4'($urandom_range(0, 14));
        else                   {r, g} = 4'($urandom);
        b = 2'($urandom);

        hs_rise = hs_a && !prev_hs;
        vs_rise = vs_a && !prev_vs;
        prev_hs = hs_a;
        prev_vs = vs_a;

        c.locked = (vs_seen >= LOCK_EDGES);
        c.chk_xy = (vs_seen >= LOCK_EDGES) && !pending_short;
        c.cv = 0; c.te = 0; c.fd = 0;
        c.x = x; c.y = y;
        err = hs_rise && pending_short && (vs_seen >= 1);
        if (hs_rise) pending_short = 0;
        if (err) begin
            c.te = 1;
            errs = (errs < 255) ? errs + 1 : 255;
            err_q.push_back(errs);
            vs_seen = 0; acc = 0;
            bits_q.delete();
        end else if (vs_rise) begin
            if (vs_seen >= LOCK_EDGES) begin
                c.fd = 1;
`ifdef VGA_DEC_CRC_EN
                ecrc = crc_of_bits();
`else
                ecrc = 16'h0000;
`endif
                fd_q.push_back('{acc, ecrc});
            end
            acc = 0;
            bits_q.delete();
            if (vs_seen < LOCK_EDGES) vs_seen++;
        end else if ((vs_seen >= LOCK_EDGES) && in_win && (cx % 8 == 3) && (cy % 8 == 3)) begin
            c.cv = 1;
            cell_q.push_back('{(cy / 8) * 64 + (cx / 8), alive});
            acc += int'(alive);
            bits_q.push_back(alive);
        end
        cyc_q.push_back(c);
    endtask

    task automatic run_frame(input int mode, input int short_line, input int rst_line);
        if (mode == 2)
            foreach (board[i, j]) board[i][j] = 1'($urandom);
        for (int y = 0; y < V_TOTAL; y++) begin
            for (int x = 0; x < ((y == short_line) ? H_TOTAL - 1 : H_TOTAL); x++) begin
                if (y == rst_line && x == 10) do_reset();
                drive_pixel(x, y, mode);
            end
            if (y == short_line) pending_short = 1;
        end
    endtask

    // Monitor: one expected record per captured sample, data popped on strobes.
    initial begin
        cyc_t  mc;
        cell_t ec;
        fd_t   ef;
        int    ee;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && cyc_q.size() > 0) begin
                mc = cyc_q.pop_front();
                checks++;
                if ({locked, cell_valid, timing_err, frame_done} !== {mc.locked, mc.cv, mc.te, mc.fd}) begin
                    errors++;
                    $display("FAIL strobes at (%0d,%0d): got locked/cv/terr/fd=%b%b%b%b required %b%b%b%b",
                             mc.x, mc.y, locked, cell_valid, timing_err, frame_done,
                             mc.locked, mc.cv, mc.te, mc.fd);
                end
                if (mc.chk_xy) begin
                    checks++;
                    if (pix_x !== 10'(mc.x) || pix_y !== 10'(mc.y)) begin
                        errors++;
                        $display("FAIL coords: got %0d,%0d required %0d,%0d", pix_x, pix_y, mc.x, mc.y);
                    end
                end
                if (cell_valid && mc.cv && cell_q.size() > 0) begin
                    ec = cell_q.pop_front();
                    checks++;
                    if (cell_index !== 11'(ec.idx) || cell_alive !== ec.alive) begin
                        errors++;
                        $display("FAIL cell: got idx=%0d alive=%0b required idx=%0d alive=%0b",
                                 cell_index, cell_alive, ec.idx, ec.alive);
                    end
                end
                if (frame_done && mc.fd && fd_q.size() > 0) begin
                    ef = fd_q.pop_front();
                    checks++;
                    if (alive_count !== 12'(ef.cnt) || frame_crc !== ef.crc) begin
                        errors++;
                        $display("FAIL frame_done: got alive_count=%0d crc=%h required %0d crc=%h",
                                 alive_count, frame_crc, ef.cnt, ef.crc);
                    end
                end
                if (timing_err && mc.te && err_q.size() > 0) begin
                    ee = err_q.pop_front();
                    checks++;
                    if (err_count !== 8'(ee)) begin
                        errors++;
                        $display("FAIL err_count: got %0d required %0d", err_count, ee);
                    end
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        hsync = ~SYNC_LVL; vsync = ~SYNC_LVL; r = '0; g = '0; b = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset_state");
        @(posedge clk);
        #3 rst_n = 1'b1;

        for (int f = 0; f < 4; f++) run_frame(2, -1, -1);   // acquire lock, random board
        run_frame(0, -1, -1);                               // all dead
        run_frame(1, -1, -1);                               // checkerboard
        run_frame(2, V_DISPLAY - 1, -1);                    // one 1-pixel-short line
        for (int f = 0; f < 3; f++) run_frame(2, -1, -1);   // relock
        run_frame(3, -1, 20);                               // reset mid-frame
        run_frame(2, -1, -1);
        run_frame(2, -1, -1);
        run_frame(3, -1, -1);                               // all alive

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (cyc_q.size() != 0 || cell_q.size() != 0 || fd_q.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got cyc=%0d cell=%0d fd=%0d err=%0d pending, required 0",
                     cyc_q.size(), cell_q.size(), fd_q.size(), err_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_frame_decoder.md
Name: vga_frame_decoder

Overview:
- Receive side of the VGA output pins: consumes hsync/vsync/RGB (2 bits per colour) from the Game of Life top level.
- Recovers pixel coordinates, checks 640x480 timing and locks to the stream.
- Decodes the displayed 64x32 board by sampling one pixel per 8x8 cell, emitting a cell stream plus per-frame statistics.
- Used as the in-bench and FPGA-side checker for the display path.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch
- SYNC_ACTIVE, 0, active level of hsync/vsync
- LOCK_FRAMES, 2, consecutive clean frames required to lock

Ports:
- clk  in  1  pixel clock, one pixel per cycle
- rst_n  in  1  reset, asynchronous, active-low
- hsync  in  1  horizontal sync from pins
- vsync  in  1  vertical sync from pins
- r  in  2  red
- g  in  2  green
- b  in  2  blue
- pix_x  out  10  recovered x of registered sample
- pix_y  out  10  recovered y of registered sample
- locked  out  1  timing locked
- timing_err  out  1  one-cycle pulse on any timing violation
- err_count  out  8  saturating violation count
- cell_valid  out  1  one-cycle cell sample strobe
- cell_index  out  11  {y[7:3], x[8:3]}
- cell_alive  out  1  sampled cell state
- frame_done  out  1  one-cycle pulse at frame end
- alive_count  out  12  live cells in last decoded frame
- frame_crc  out  16  CRC of last frame's cell stream (optional feature)

Behaviour:
- Reset: all outputs 0; FSM in SEARCH; counters 0.
- Inputs are registered once. Every derived output refers to that registered sample, so latency is 1 cycle from the pins.
- H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525).
- hsync assertion edge (registered): sample gets x = H_DISPLAY+H_FRONT (656). x otherwise increments and wraps H_TOTAL-1 -> 0. y increments on each x wrap and wraps at V_TOTAL-1.
- vsync assertion edge: the current line's y is forced to V_DISPLAY+V_FRONT (490).
- FSM states:
  - SEARCH: waits for a vsync edge, then goes to TRACK with good_frames = 0.
  - TRACK: on every vsync edge with no error in the elapsed frame, good_frames++. At LOCK_FRAMES it goes to LOCKED.
  - LOCKED: the only state that produces cell_valid and frame_done.
  - Any violation in TRACK or LOCKED: timing_err pulses, err_count increments (saturating at 255), FSM returns to SEARCH, locked drops on the next cycle.
- Violations:
  - hsync edge while predicted x != 656.
  - hsync deassertion after other than H_SYNC cycles.
  - vsync edge while predicted y != 490 or x != 0.
  - vsync deasserting after other than V_SYNC lines.
  - In SEARCH, none of these checks apply.
- Cell decode, in LOCKED only:
  - Sampling window: 64 <= x < 576 and 112 <= y < 368.
  - A sample is taken when x[2:0]==3 and y[2:0]==3.
  - On a sample: cell_valid=1, cell_index={y[7:3],x[8:3]}, cell_alive = (r==2'b11 && g==2'b11).
- alive_count:
  - Internal accumulator, 12 bits; it cannot overflow (max 2048).
  - On the vsync edge in LOCKED, the accumulator is copied to alive_count, frame_done pulses and the accumulator clears.
  - Same-cycle cell_valid and vsync edge cannot occur because the window excludes it.
- Reset mid-frame: immediate return to the reset state. alive_count and frame_crc are cleared.

Optional Feature:
- Macro: VGA_DEC_CRC_EN
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF), shifted one bit per cell_valid with cell_alive as data, MSB-first.
  - Latched into frame_crc with frame_done, then re-initialised to 0xFFFF.
- Undefined: frame_crc tied to 16'h0000 and no CRC logic is synthesised.

Test Plan:
- Reset release followed by 3 ideal 640x480 frames -> locked=1 after the vsync edge completing frame 2; timing_err never pulses; err_count=0.
- Locked, then one line shortened to 799 cycles -> timing_err one pulse at the early hsync edge; locked=0 next cycle; err_count=1; relock after 2 clean frames.
- Locked, board all-dead (R=G=2'b01 in window) -> exactly 2048 cell_valid pulses per frame; alive_count=0 at frame_done.
- Locked, checkerboard with cell alive iff x[3]^y[3] -> alive_count=1024; cell_index 0 is dead, index 1 is alive.
- rst_n asserted mid-frame (y=200) -> all outputs 0 asynchronously; locked only after 2 further full frames.
- With VGA_DEC_CRC_EN, all-dead frame -> frame_crc equals the software CRC of 2048 zero bits from 0xFFFF; without the macro, frame_crc=0.
